// File: rtl/mult4_pkg.sv
// Shared state encoding and per-step select table for the 4x4 multiplier sequencer.
package mult4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_P0   = 3'd2,
    ST_P1   = 3'd3,
    ST_P2   = 3'd4,
    ST_P3   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // {s0,s1,s2} per partial-product step, Horner order aH*bH first
  localparam logic [2:0] SEL_P0 = 3'b000;
  localparam logic [2:0] SEL_P1 = 3'b011;
  localparam logic [2:0] SEL_P2 = 3'b100;
  localparam logic [2:0] SEL_P3 = 3'b111;

  function automatic logic [2:0] step_sel(input state_t s);
    case (s)
      ST_P0:   step_sel = SEL_P0;
      ST_P1:   step_sel = SEL_P1;
      ST_P2:   step_sel = SEL_P2;
      ST_P3:   step_sel = SEL_P3;
      default: step_sel = 3'b000;
    endcase
  endfunction

  function automatic logic is_step(input state_t s);
    is_step = (s == ST_P0) || (s == ST_P1) || (s == ST_P2) || (s == ST_P3);
  endfunction

endpackage

// File: rtl/mult4_ctrl.sv
// Start/done sequencer driving ld, selects and accumulator clear of the 4x4 multiplier datapath.
// state   | meaning
// IDLE    | ready, waiting for start
// CLR     | one-cycle accumulator/operand clear
// P0..P3  | partial-product steps, STEP_CYCLES each, ld on last cycle
// DONE    | one-cycle done pulse, product valid
module mult4_ctrl
  import mult4_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ready,
  output logic busy,
  output logic acc_clr,
  output logic ld,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic done
);

  localparam logic [1:0] LAST = 2'(STEP_CYCLES - 1);

  state_t     state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic       step_end;

  assign step_end = (cnt == LAST);

  always_comb begin
    state_nx = state;
    cnt_nx   = 2'd0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_CLR;
      ST_CLR:  state_nx = ST_P0;
      ST_P0:   if (step_end) state_nx = ST_P1; else cnt_nx = cnt + 2'd1;
      ST_P1:   if (step_end) state_nx = ST_P2; else cnt_nx = cnt + 2'd1;
      ST_P2:   if (step_end) state_nx = ST_P3; else cnt_nx = cnt + 2'd1;
      ST_P3:   if (step_end) state_nx = ST_DONE; else cnt_nx = cnt + 2'd1;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are flops aligned with the state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      acc_clr <= 1'b0;
      ld      <= 1'b0;
      s0      <= 1'b0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      done    <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      ready        <= (state_nx == ST_IDLE);
      busy         <= (state_nx == ST_CLR) || is_step(state_nx);
      acc_clr      <= (state_nx == ST_CLR);
      ld           <= is_step(state_nx) && (cnt_nx == LAST);
      {s0, s1, s2} <= step_sel(state_nx);
      done         <= (state_nx == ST_DONE);
    end
  end

endmodule

// File: tb/tb_mult4_ctrl.sv
// Bench for mult4_ctrl: two instances (STEP_CYCLES 1 and 3) each feeding an emulated datapath.
module tb_mult4_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start [2];
  logic ready [2], busy [2], acc_clr [2], ld [2], s0 [2], s1 [2], s2 [2], done [2];
  logic [3:0] a [2], b [2];
  logic [7:0] c [2];
  int tests = 0;
  int fails = 0;
  int accepted [2];
  int dn0 = 0, dn1 = 0;

  always #5 clk = ~clk;

  mult4_ctrl #(.STEP_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start[0]), .ready(ready[0]), .busy(busy[0]),
    .acc_clr(acc_clr[0]), .ld(ld[0]), .s0(s0[0]), .s1(s1[0]), .s2(s2[0]), .done(done[0])
  );

  mult4_ctrl #(.STEP_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .start(start[1]), .ready(ready[1]), .busy(busy[1]),
    .acc_clr(acc_clr[1]), .ld(ld[1]), .s0(s0[1]), .s1(s1[1]), .s2(s2[1]), .done(done[1])
  );

  // Datapath emulation: reset on system reset or acc_clr, accumulate one 2x2 product per ld
  for (genvar g = 0; g < 2; g++) begin : g_dp
    logic [7:0] c_r;
    logic [1:0] ah, bh;
    assign ah   = s0[g] ? a[g][1:0] : a[g][3:2];
    assign bh   = s1[g] ? b[g][1:0] : b[g][3:2];
    assign c[g] = c_r;
    always @(posedge clk) begin
      if (!rst || acc_clr[g]) c_r <= 8'd0;
      else if (ld[g]) c_r <= (s2[g] ? {c_r[5:0], 2'b00} : c_r) + {4'd0, 2'd0, ah} * {4'd0, 2'd0, bh};
    end
  end

  always @(negedge clk) begin
    if (done[0] === 1'b1) dn0++;
    if (done[1] === 1'b1) dn1++;
  end

  localparam logic [7:0] V_IDLE = 8'b1000_0000;
  localparam logic [7:0] V_CLR  = 8'b0110_0000;
  localparam logic [7:0] V_DONE = 8'b0000_0001;

  function automatic logic [7:0] vec(input int w);
    return {ready[w], busy[w], acc_clr[w], ld[w], s0[w], s1[w], s2[w], done[w]};
  endfunction

  // Step i of 4 uses s0 = upper bit of i, s1 = s2 = lower bit of i
  function automatic logic [7:0] step_vec(input int i, input int j, input int sc);
    logic [1:0] iv;
    iv = 2'(i);
    return {1'b0, 1'b1, 1'b0, (j == sc - 1), iv[1], iv[0], iv[0], 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE
  task automatic op(input int w, input int sc, input logic [3:0] av, input logic [3:0] bv,
                    input bit keep, input bit noise);
    int prod;
    prod = int'(av) * int'(bv);
    a[w] = av;
    b[w] = bv;
    start[w] = 1'b1;
    accepted[w]++;
    @(negedge clk);
    chk($sformatf("clr w%0d", w), {24'd0, vec(w)}, {24'd0, V_CLR});
    if (!keep) start[w] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < sc; j++) begin
        @(negedge clk);
        chk($sformatf("step%0d.%0d w%0d", i, j, w), {24'd0, vec(w)}, {24'd0, step_vec(i, j, sc)});
        if (noise) start[w] = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    chk($sformatf("done w%0d", w), {24'd0, vec(w)}, {24'd0, V_DONE});
    chk($sformatf("prod %0h*%0h w%0d", av, bv, w), {24'd0, c[w]}, prod);
    if (noise) start[w] = 1'b1;
    @(negedge clk);
    chk($sformatf("idle w%0d", w), {24'd0, vec(w)}, {24'd0, V_IDLE});
    if (!keep) start[w] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    accepted[0] = 0;
    accepted[1] = 0;
    for (int w = 0; w < 2; w++) begin
      start[w] = 1'b0;
      a[w] = 4'd0;
      b[w] = 4'd0;
    end
    repeat (2) @(negedge clk);
    chk("reset w0", {24'd0, vec(0)}, {24'd0, V_IDLE});
    chk("reset w1", {24'd0, vec(1)}, {24'd0, V_IDLE});
    rst = 1'b1;
    @(negedge clk);
    chk("idle hold", {24'd0, vec(0)}, {24'd0, V_IDLE});

    op(0, 1, 4'hF, 4'hF, 1'b0, 1'b0);
    op(0, 1, 4'h7, 4'h9, 1'b0, 1'b0);
    op(0, 1, 4'h0, 4'hD, 1'b0, 1'b0);
    op(0, 1, 4'hA, 4'h1, 1'b0, 1'b0);
    op(1, 3, 4'h5, 4'h6, 1'b0, 1'b0);

    // start held: three back-to-back operations, one IDLE cycle between them
    op(0, 1, 4'h3, 4'hC, 1'b1, 1'b0);
    op(0, 1, 4'h9, 4'h9, 1'b1, 1'b0);
    op(0, 1, 4'hE, 4'h7, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b settle", {24'd0, vec(0)}, {24'd0, V_IDLE});

    for (int n = 0; n < 8; n++) begin
      op(0, 1, 4'($urandom), 4'($urandom), 1'b0, 1'b1);
      @(negedge clk);
      chk("no queued start w0", {24'd0, vec(0)}, {24'd0, V_IDLE});
      op(1, 3, 4'($urandom), 4'($urandom), 1'b0, 1'b1);
      @(negedge clk);
      chk("no queued start w1", {24'd0, vec(1)}, {24'd0, V_IDLE});
    end

    // Abort mid-P1 with a two-cycle reset
    a[0] = 4'hB;
    b[0] = 4'h6;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-abort P1", {24'd0, vec(0)}, {24'd0, step_vec(1, 0, 1)});
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("abort idle", {24'd0, vec(0)}, {24'd0, V_IDLE});
    repeat (6) begin
      @(negedge clk);
      chk("after abort", {24'd0, vec(0)}, {24'd0, V_IDLE});
    end

    chk("done count w0", dn0, accepted[0]);
    chk("done count w1", dn1, accepted[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult4_ctrl.md
Name: mult4_ctrl

Overview:
- Sequencing controller for the 4x4 gate-level multiplier datapath.
- Sits directly upstream of the datapath and drives its ld, s0, s1, s2 and accumulator-clear inputs.
- Performs a start/done handshake with the requester.
- Computes the 8-bit product in four 2x2 partial-product accumulate steps (Horner order).

Parameters:
- STEP_CYCLES, default 1: cycles each accumulate step holds its selects; ld asserts only in the last cycle of a step (range 1..4).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- ready  out  1  high in IDLE; a new start is accepted
- busy  out  1  high from CLR through P3; operands a/b must stay stable
- acc_clr  out  1  one-cycle clear of datapath accumulator/operand registers
- ld  out  1  datapath register load enable
- s0  out  1  A-half select: 0 = a[3:2], 1 = a[1:0]
- s1  out  1  B-half select: 0 = b[3:2], 1 = b[1:0]
- s2  out  1  accumulator path: 0 = c, 1 = c<<2
- done  out  1  one-cycle pulse; product c valid this cycle and held afterwards

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, step counter=0.
  - Outputs: ready=1; busy=0, acc_clr=0, ld=0, s0=0, s1=0, s2=0, done=0.
- Reset asserted mid-operation aborts immediately. No done is produced.
- States: IDLE, CLR, P0, P1, P2, P3, DONE. One-hot or binary encoding is allowed.
- IDLE: ready=1. When start=1, go to CLR; otherwise stay in IDLE.
- CLR: one cycle, acc_clr=1, then go to P0.
- Step sequence (s0, s1, s2), with ld asserted on the last cycle of each step:
  - P0: (0,0,0), c = 0 + aH*bH
  - P1: (0,1,1), c = (c<<2) + aH*bL
  - P2: (1,0,0), c = c + aL*bH
  - P3: (1,1,1), c = (c<<2) + aL*bL
  - Result: aH*bH*16 + (aH*bL + aL*bH)*4 + aL*bL = a*b.
- Each Pn lasts STEP_CYCLES cycles, counted by a 2-bit step counter.
  - Counter clears on state entry.
  - Selects stay constant for the whole step.
  - ld=1 only when counter = STEP_CYCLES-1.
- After P3 the next state is DONE.
- DONE: one cycle, done=1, ld=0, then go to IDLE.
  - The datapath register c already holds the final product in DONE.
- Latency: start sampled at edge k gives done high during cycle k + 2 + 4*STEP_CYCLES (CLR plus steps).
  - STEP_CYCLES=1 gives done in the 6th cycle after start.
- start outside IDLE is ignored; there is no queueing.
- start held high continuously: a new operation begins in the cycle after DONE (back-to-back). ready is high for exactly that one IDLE cycle.
- Outputs are registered. ld, s0, s1, s2, acc_clr and done are glitch-free for the datapath.
- In IDLE, CLR and DONE, selects are 0 and ld=0.
- Integration: datapath rst is driven from (system reset active) OR acc_clr.
  - Datapath ld also reloads the operand registers on each step, hence the busy stability rule on a/b.

Decomposition:
- Shared package/include holds:
  - state encoding constants: ST_IDLE, ST_CLR, ST_P0..ST_P3, ST_DONE
  - per-step select table constants: SEL_P0..SEL_P3 as 3-bit {s0,s1,s2}
- No sub-module is needed; the step counter is inline.
- A top mult4_top instantiates mult4_ctrl plus the datapath.

Test Plan:
- Reset: rst=0 for 2 cycles mid-P1 -> next cycle state IDLE, ready=1, all other outputs 0, no done.
- Single multiply, STEP_CYCLES=1, a=4'hF, b=4'hF, start 1 cycle -> selects 000,011,100,111 on successive cycles, ld high 4 cycles, done in 6th cycle after start, c=8'hE1.
- Products via top: a=4'h7, b=4'h9 -> c=8'h3F; a=0, b=4'hD -> c=8'h00; a=4'hA, b=4'h1 -> c=8'h0A.
- Back-to-back: start held high for 3 operations -> three done pulses 7 cycles apart, ready high one cycle between them.
- STEP_CYCLES=3: a=4'h5, b=4'h6 -> each select set held 3 cycles, ld only on 3rd cycle, done 14 cycles after start, c=8'h1E.
- start pulses during busy and during DONE -> ignored; exactly one done per accepted start.
